enybul_app: RTL and testbench
=============================

# enybul_app

Enemy-bullet controller; sits directly downstream of the enemy-tank application block. Accepts the tank's fire request, launches one bullet from the tank's cell in the tank's facing direction, and advances it one grid cell per movement tick. Retires the bullet at the playfield edge or on contact with the player's tank, and returns the busy status the tank uses to gate its next shot.

## Interface
- X_MAX, 16: largest legal x cell
- Y_MAX, 20: largest legal y cell
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- step_tick  in  1  one-clk-wide movement strobe (4 Hz rate)
- fire_req  in  1  enemy tank's shoot request (level)
- tank_alive  in  1  enemy tank present
- tank_xpos, tank_ypos  in  5  enemy tank cell
- tank_dir  in  2  facing: 00 y-1, 01 y+1, 10 x-1, 11 x+1
- mytank_xpos, mytank_ypos  in  5  player tank cell
- mybul_valid  in  1  player bullet in flight (used only with ENYBUL_CANCEL_EN)
- mybul_x, mybul_y  in  5  player bullet cell
- enybul_state_feedback  out  1  bullet in flight
- enybul_x, enybul_y  out  5  bullet cell
- enybul_dir  out  2  latched flight direction
- hit_mytank  out  1  one-clk pulse: player tank struck
- bul_cancel  out  1  one-clk pulse: bullets annihilated (tied 0 without macro)

## Operation
- FSM states: IDLE, FLY.
- IDLE: if fire_req && tank_alive, load the bullet cell from tank_xpos/ypos and enybul_dir from tank_dir, then go to FLY. Otherwise hold.
- FLY, on step_tick: compute the next cell from enybul_dir.
  - If the next cell leaves 0..X_MAX / 0..Y_MAX, go to IDLE. Position holds at its last legal value.
  - Otherwise move to the next cell.
- Edge detection uses unsigned compares before update: x==0 with dir 10, x==X_MAX with dir 11, y==0 with dir 00, y==Y_MAX with dir 01. No wrap-around ever.
- Hit check runs every cycle in FLY. When the bullet cell equals the player cell, pulse hit_mytank for one cycle and go to IDLE. This includes launch onto the player's cell, which is detected the cycle after launch.
- tank_alive falling mid-flight does not affect the bullet; it keeps flying.
- fire_req held high while in FLY is ignored. No queuing.
- After retirement, if fire_req is still high in IDLE, relaunch occurs on the next clk.

## Timing
- Reset values: state IDLE; enybul_state_feedback 0; enybul_x/y 0; enybul_dir 00; hit_mytank 0; bul_cancel 0.
- Reset asserted mid-flight aborts the bullet immediately (asynchronous). No pulse is emitted.
- Launch: request sampled at edge N; feedback=1 and position valid after edge N.
- step_tick coinciding with the launch edge is consumed by the launch. The first move occurs on the next step_tick.
- Move: registered at the step_tick edge; one-cycle latency.
- Hit and edge retirement:
  - feedback drops on the same edge that hit_mytank rises.
  - hit_mytank is high exactly one clk.
- Hit and edge-exit in the same cycle: the hit takes priority and the pulse is emitted.

## Configuration
- ENYBUL_CANCEL_EN defined: in FLY, mybul_valid && bullet cell == (mybul_x, mybul_y) pulses bul_cancel one clk and returns to IDLE.
  - Priority: hit_mytank > bul_cancel > edge exit.
  - The player-bullet block consumes bul_cancel.
- ENYBUL_CANCEL_EN undefined: mybul_* are ignored and bul_cancel is constant 0.

## Structure
- Shared package holds:
  - direction encodings DIR_UP=00, DIR_DOWN=01, DIR_LEFT=10, DIR_RIGHT=11;
  - grid limits;
  - the state enum.
- One sub-module, grid_step: combinational next-cell plus out-of-bounds flag from (x, y, dir, limits). Reused by tank movers.

## Test plan
- Reset mid-flight:
  - launch at (8,10) dir 00, two ticks -> bullet at (8,8);
  - assert rst_n=0 -> all outputs 0 immediately.
- Launch and travel: tank (5,5) dir 11, fire_req one clk -> feedback=1, cell (5,5) next cycle; three step_ticks -> (8,5).
- Edge retirement: launch at (16,3) dir 11, step_tick -> feedback 0 at that edge, no hit_mytank.
- Player hit:
  - player at (2,7), launch at (2,10) dir 00;
  - after three ticks the bullet reaches (2,7) -> hit_mytank single pulse, feedback 0 same edge.
- Busy gating:
  - fire_req held high through flight -> no relaunch while feedback=1;
  - relaunch exactly one clk after retirement;
  - step_tick on the launch edge does not move the bullet.
- Cancel (macro on):
  - enemy bullet at (4,4) dir 10, mybul_valid with mybul (3,4);
  - next tick -> bul_cancel pulse, feedback 0;
  - with macro off -> bullet continues to (3,4), then (2,4).

Source files
------------

// File: rtl/enybul_app_pkg.sv
// Shared definitions for the enemy-bullet controller and the grid movers:
// direction encodings, playfield limits and the bullet FSM state type.
package enybul_app_pkg;

  localparam int unsigned CELL_W = 5;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned GRID_X_MAX = 16;
  localparam int unsigned GRID_Y_MAX = 20;

  typedef enum logic {
    IDLE,
    FLY
  } state_e;

endpackage

// File: rtl/enybul_app_grid_step.sv
// One-cell step on the playfield grid: next cell plus an out-of-bounds flag.
// Never wraps; when the step would leave the grid the cell is returned unchanged.
module grid_step
  import enybul_app_pkg::*;
(
  input  logic [CELL_W-1:0] x_i,
  input  logic [CELL_W-1:0] y_i,
  input  logic [1:0]        dir_i,
  input  logic [CELL_W-1:0] x_max_i,
  input  logic [CELL_W-1:0] y_max_i,
  output logic [CELL_W-1:0] x_o,
  output logic [CELL_W-1:0] y_o,
  output logic              oob_o
);

  always_comb begin
    x_o   = x_i;
    y_o   = y_i;
    oob_o = 1'b0;
    case (dir_i)
      DIR_UP:    if (y_i == '0)      oob_o = 1'b1; else y_o = y_i - 1'b1;
      DIR_DOWN:  if (y_i == y_max_i) oob_o = 1'b1; else y_o = y_i + 1'b1;
      DIR_LEFT:  if (x_i == '0)      oob_o = 1'b1; else x_o = x_i - 1'b1;
      default:   if (x_i == x_max_i) oob_o = 1'b1; else x_o = x_i + 1'b1;
    endcase
  end

endmodule

// File: rtl/enybul_app.sv
// Enemy-bullet controller: launches one bullet from the enemy tank, steps it
// per movement tick, retires it at the edge or on the player tank.
// Optional bullet/bullet annihilation is enabled by defining ENYBUL_CANCEL_EN.
module enybul_app
  import enybul_app_pkg::*;
#(
  parameter int unsigned X_MAX = GRID_X_MAX,
  parameter int unsigned Y_MAX = GRID_Y_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_tick,
  input  logic              fire_req,
  input  logic              tank_alive,
  input  logic [CELL_W-1:0] tank_xpos,
  input  logic [CELL_W-1:0] tank_ypos,
  input  logic [1:0]        tank_dir,
  input  logic [CELL_W-1:0] mytank_xpos,
  input  logic [CELL_W-1:0] mytank_ypos,
  input  logic              mybul_valid,
  input  logic [CELL_W-1:0] mybul_x,
  input  logic [CELL_W-1:0] mybul_y,
  output logic              enybul_state_feedback,
  output logic [CELL_W-1:0] enybul_x,
  output logic [CELL_W-1:0] enybul_y,
  output logic [1:0]        enybul_dir,
  output logic              hit_mytank,
  output logic              bul_cancel
);

  localparam logic [CELL_W-1:0] XLIM = CELL_W'(X_MAX);
  localparam logic [CELL_W-1:0] YLIM = CELL_W'(Y_MAX);

  state_e            state_q;
  logic              fb_q, hit_q, cancel_q;
  logic [CELL_W-1:0] x_q, y_q;
  logic [1:0]        dir_q;

  logic [CELL_W-1:0] step_x_d, step_y_d;
  logic              step_oob_d;
  logic              at_player, cancel_hit;

  grid_step u_step (
    .x_i     (x_q),
    .y_i     (y_q),
    .dir_i   (dir_q),
    .x_max_i (XLIM),
    .y_max_i (YLIM),
    .x_o     (step_x_d),
    .y_o     (step_y_d),
    .oob_o   (step_oob_d)
  );

  assign at_player = (x_q == mytank_xpos) && (y_q == mytank_ypos);

`ifdef ENYBUL_CANCEL_EN
  assign cancel_hit = mybul_valid && (x_q == mybul_x) && (y_q == mybul_y);
`else
  logic unused_mybul;
  assign unused_mybul = ^{mybul_valid, mybul_x, mybul_y};
  assign cancel_hit   = 1'b0;
`endif

  // Priority in flight: player hit, then annihilation, then tick-driven move/exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fb_q     <= 1'b0;
      hit_q    <= 1'b0;
      cancel_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DIR_UP;
    end else begin
      hit_q    <= 1'b0;
      cancel_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire_req && tank_alive) begin
            x_q     <= tank_xpos;
            y_q     <= tank_ypos;
            dir_q   <= tank_dir;
            fb_q    <= 1'b1;
            state_q <= FLY;
          end
        end
        default: begin
          if (at_player) begin
            hit_q   <= 1'b1;
            fb_q    <= 1'b0;
            state_q <= IDLE;
          end else if (cancel_hit) begin
            cancel_q <= 1'b1;
            fb_q     <= 1'b0;
            state_q  <= IDLE;
          end else if (step_tick) begin
            if (step_oob_d) begin
              fb_q    <= 1'b0;
              state_q <= IDLE;
            end else begin
              x_q <= step_x_d;
              y_q <= step_y_d;
            end
          end
        end
      endcase
    end
  end

  assign enybul_state_feedback = fb_q;
  assign enybul_x              = x_q;
  assign enybul_y              = y_q;
  assign enybul_dir            = dir_q;
  assign hit_mytank            = hit_q;
  assign bul_cancel            = cancel_q;

endmodule

// File: tb/tb_enybul_app.sv
// Bench for enybul_app: directed scenarios then randomized traffic, all
// compared against a cell-arithmetic reference model of the bullet.
module tb_enybul_app;

`ifdef ENYBUL_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif
  localparam int XM = 16;
  localparam int YM = 20;

  logic       clk = 1'b0;
  logic       rst_n, step_tick, fire_req, tank_alive, mybul_valid;
  logic [4:0] tank_xpos, tank_ypos, mytank_xpos, mytank_ypos, mybul_x, mybul_y;
  logic [1:0] tank_dir;
  logic       enybul_state_feedback, hit_mytank, bul_cancel;
  logic [4:0] enybul_x, enybul_y;
  logic [1:0] enybul_dir;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bit m_fly, m_hit, m_cancel;
  int m_x, m_y, m_dir;

  always #5 clk = ~clk;

  enybul_app #(.X_MAX(16), .Y_MAX(20)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .step_tick             (step_tick),
    .fire_req              (fire_req),
    .tank_alive            (tank_alive),
    .tank_xpos             (tank_xpos),
    .tank_ypos             (tank_ypos),
    .tank_dir              (tank_dir),
    .mytank_xpos           (mytank_xpos),
    .mytank_ypos           (mytank_ypos),
    .mybul_valid           (mybul_valid),
    .mybul_x               (mybul_x),
    .mybul_y               (mybul_y),
    .enybul_state_feedback (enybul_state_feedback),
    .enybul_x              (enybul_x),
    .enybul_y              (enybul_y),
    .enybul_dir            (enybul_dir),
    .hit_mytank            (hit_mytank),
    .bul_cancel            (bul_cancel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fly = 0; m_hit = 0; m_cancel = 0; m_x = 0; m_y = 0; m_dir = 0;
  endtask

  // Behaviour of one clock edge, expressed as signed cell arithmetic.
  task automatic model_step();
    int dx, dy, nx, ny;
    m_hit = 0;
    m_cancel = 0;
    if (!m_fly) begin
      if (fire_req && tank_alive) begin
        m_x = int'(tank_xpos); m_y = int'(tank_ypos); m_dir = int'(tank_dir); m_fly = 1;
      end
    end else if (m_x == int'(mytank_xpos) && m_y == int'(mytank_ypos)) begin
      m_hit = 1; m_fly = 0;
    end else if (CANCEL && mybul_valid && m_x == int'(mybul_x) && m_y == int'(mybul_y)) begin
      m_cancel = 1; m_fly = 0;
    end else if (step_tick) begin
      dx = (m_dir == 3) ? 1 : (m_dir == 2) ? -1 : 0;
      dy = (m_dir == 1) ? 1 : (m_dir == 0) ? -1 : 0;
      nx = m_x + dx;
      ny = m_y + dy;
      if (nx < 0 || nx > XM || ny < 0 || ny > YM) m_fly = 0;
      else begin m_x = nx; m_y = ny; end
    end
  endtask

  task automatic check_model();
    chk("feedback", 32'(enybul_state_feedback), 32'(m_fly));
    chk("x", 32'(enybul_x), m_x);
    chk("y", 32'(enybul_y), m_y);
    chk("dir", 32'(enybul_dir), m_dir);
    chk("hit", 32'(hit_mytank), 32'(m_hit));
    chk("cancel", 32'(bul_cancel), 32'(m_cancel));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic launch(input int x, input int y, input int d);
    tank_xpos = 5'(x); tank_ypos = 5'(y); tank_dir = 2'(d);
    fire_req = 1; tank_alive = 1;
    step();
    fire_req = 0;
  endtask

  initial begin
    rst_n = 0; step_tick = 0; fire_req = 0; tank_alive = 0;
    tank_xpos = 0; tank_ypos = 0; tank_dir = 0;
    mytank_xpos = 31; mytank_ypos = 31;
    mybul_valid = 0; mybul_x = 31; mybul_y = 31;
    model_reset();
    #1;
    chk("reset_fb", 32'(enybul_state_feedback), 0);
    check_model();
    @(posedge clk); #1;
    rst_n = 1;

    // Reset mid-flight
    launch(8, 10, 0);
    step_tick = 1; step(); step(); step_tick = 0;
    chk("rst_pre_y", 32'(enybul_y), 8);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_async_fb", 32'(enybul_state_feedback), 0);
    chk("rst_async_y", 32'(enybul_y), 0);
    check_model();
    @(posedge clk); #1;
    rst_n = 1;

    // Launch and travel
    launch(5, 5, 3);
    chk("launch_fb", 32'(enybul_state_feedback), 1);
    chk("launch_x", 32'(enybul_x), 5);
    step_tick = 1; repeat (3) step(); step_tick = 0;
    chk("travel_x", 32'(enybul_x), 8);
    chk("travel_y", 32'(enybul_y), 5);
    step_tick = 1; repeat (9) step(); step_tick = 0;
    chk("travel_retired", 32'(enybul_state_feedback), 0);

    // Edge retirement at x == X_MAX
    launch(16, 3, 3);
    step_tick = 1; step(); step_tick = 0;
    chk("edge_fb", 32'(enybul_state_feedback), 0);
    chk("edge_nohit", 32'(hit_mytank), 0);
    chk("edge_hold_x", 32'(enybul_x), 16);

    // Player hit
    mytank_xpos = 2; mytank_ypos = 7;
    launch(2, 10, 0);
    step_tick = 1; repeat (3) step(); step_tick = 0;
    chk("hit_arrive_y", 32'(enybul_y), 7);
    step();
    chk("hit_pulse", 32'(hit_mytank), 1);
    chk("hit_fb", 32'(enybul_state_feedback), 0);
    step();
    chk("hit_once", 32'(hit_mytank), 0);
    mytank_xpos = 31; mytank_ypos = 31;

    // Busy gating: tick on launch edge, held fire_req, relaunch after exit
    tank_xpos = 10; tank_ypos = 10; tank_dir = 1; tank_alive = 1; fire_req = 1;
    step_tick = 1;
    step();
    chk("gate_launch_y", 32'(enybul_y), 10);
    repeat (11) step();
    chk("gate_retired", 32'(enybul_state_feedback), 0);
    step();
    chk("gate_relaunch", 32'(enybul_state_feedback), 1);
    chk("gate_relaunch_y", 32'(enybul_y), 10);
    fire_req = 0;
    repeat (11) step();
    step_tick = 0;

    // Bullet/bullet annihilation
    launch(4, 4, 2);
    mybul_valid = 1; mybul_x = 3; mybul_y = 4;
    step_tick = 1; step(); step_tick = 0;
    step();
    if (CANCEL) begin
      chk("cancel_pulse", 32'(bul_cancel), 1);
      chk("cancel_fb", 32'(enybul_state_feedback), 0);
    end else begin
      chk("nocancel_x", 32'(enybul_x), 3);
      step_tick = 1; step(); step_tick = 0;
      chk("nocancel_x2", 32'(enybul_x), 2);
      chk("nocancel_pulse", 32'(bul_cancel), 0);
    end
    step_tick = 1; repeat (4) step(); step_tick = 0;
    mybul_valid = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step_tick  = ($urandom_range(3) == 0);
      fire_req   = ($urandom_range(3) != 0);
      tank_alive = ($urandom_range(7) != 0);
      tank_xpos  = 5'($urandom_range(XM));
      tank_ypos  = 5'($urandom_range(YM));
      tank_dir   = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) begin
        mytank_xpos = 5'($urandom_range(XM));
        mytank_ypos = 5'($urandom_range(YM));
      end
      mybul_valid = ($urandom_range(1) == 1);
      mybul_x     = 5'($urandom_range(XM));
      mybul_y     = 5'($urandom_range(YM));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
